// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes
// and the mux/ALU select values driven onto the datapath.
package multi_cycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/mc_wait_timer.sv
// Consecutive memory-wait counter; flags when the count sits at limit-1 so the
// controller can fault instead of taking one more wait cycle.
module mc_wait_timer #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_count,
  input  logic [W-1:0] i_limit,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == i_limit - 1'b1);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute and drives the
// datapath selects, with sticky illegal-opcode and memory-timeout faults.
module multi_cycle_ctrl
  import multi_cycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o,
  output logic [3:0] state_o,
  output logic       illegal_o,
  output logic       timeout_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e r_state;
  logic   r_illegal;
  logic   r_timeout;
  logic   w_wait_st;
  logic   w_clear;
  logic   w_count;
  logic   w_expired;
  logic   w_timeout;

  // Only the three memory-facing states look at mem_ready_i; everywhere else
  // the counter is held clear so each wait state is entered from zero.
  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_clear   = !w_wait_st || mem_ready_i;
  assign w_count   = w_wait_st && !mem_ready_i;
  assign w_timeout = w_count && w_expired;

  mc_wait_timer #(
    .W(CNT_W)
  ) u_wait_timer (
    .i_clk     (clk_i),
    .i_rst_n   (rst_i),
    .i_clear   (w_clear),
    .i_count   (w_count),
    .i_limit   (CNT_W'(MEM_TIMEOUT)),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_state   <= S_FAULT;
      r_timeout <= 1'b1;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready_i) r_state <= S_DECODE;
        S_DECODE: begin
          case (instr_op_i)
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_RTYPE:     r_state <= (funct_i == FUNCT_JR) ? S_JR : S_R_EXEC;
            OP_ADDI:      r_state <= S_I_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_JAL:       r_state <= S_JAL;
            default: begin
              r_state   <= S_FAULT;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: r_state <= (instr_op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready_i) r_state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready_i) r_state <= S_FETCH;
        S_R_EXEC:   r_state <= S_R_WB;
        S_I_EXEC:   r_state <= S_I_WB;
        S_FAULT:    r_state <= S_FAULT;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Outputs decode from state alone except the two strobe qualifiers; reset
  // gates everything so no write strobe survives an aborted instruction.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    iord_o       = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    reg_dst_o    = REGDST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    alu_src_b_o  = SRCB_RT;
    pc_src_o     = PCSRC_ALU;
    alu_op_o     = ALU_ADD;
    if (rst_i) begin
      case (r_state)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = SRCB_FOUR;
          pc_write_o  = mem_ready_i;
          ir_write_o  = mem_ready_i;
        end
        S_DECODE:   alu_src_b_o = SRCB_SEXT_SH;
        S_MEM_ADDR, S_I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = SRCB_SEXT;
        end
        S_MEM_RD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = M2R_MDR;
        end
        S_MEM_WR: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = REGDST_RD;
        end
        S_I_WB:     reg_write_o = 1'b1;
        S_BRANCH: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          pc_src_o    = PCSRC_ALUOUT;
          pc_write_o  = zero_i;
        end
        S_JUMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = PCSRC_JUMP;
        end
        S_JAL: begin
          pc_write_o   = 1'b1;
          pc_src_o     = PCSRC_JUMP;
          reg_write_o  = 1'b1;
          reg_dst_o    = REGDST_RA;
          mem_to_reg_o = M2R_PC;
        end
        S_JR: begin
          pc_write_o = 1'b1;
          pc_src_o   = PCSRC_RS;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = r_state;
  assign illegal_o = r_illegal;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: default-timeout unit (a) for the
// instruction mix and reset, MEM_TIMEOUT=4 unit (b) for timeout faults.
module tb_multi_cycle_ctrl;
  import multi_cycle_pkg::*;

  logic       clk;
  logic       rst_a, rst_b, rdy_a, rdy_b;
  logic [5:0] op, funct;
  logic       zero;

  logic       pcw_a, irw_a, mr_a, mw_a, io_a, rw_a, asa_a, ill_a, to_a;
  logic [1:0] rd_a, m2r_a, asb_a, pcs_a;
  logic [2:0] aop_a;
  logic [3:0] st_a;
  logic       pcw_b, irw_b, mr_b, mw_b, io_b, rw_b, asa_b, ill_b, to_b;
  logic [1:0] rd_b, m2r_b, asb_b, pcs_b;
  logic [2:0] aop_b;
  logic [3:0] st_b;

  multi_cycle_ctrl u_dut_a (
    .clk_i(clk), .rst_i(rst_a), .instr_op_i(op), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(rdy_a), .pc_write_o(pcw_a), .ir_write_o(irw_a), .mem_read_o(mr_a),
    .mem_write_o(mw_a), .iord_o(io_a), .reg_write_o(rw_a), .alu_src_a_o(asa_a),
    .reg_dst_o(rd_a), .mem_to_reg_o(m2r_a), .alu_src_b_o(asb_a), .pc_src_o(pcs_a),
    .alu_op_o(aop_a), .state_o(st_a), .illegal_o(ill_a), .timeout_o(to_a)
  );

  multi_cycle_ctrl #(.MEM_TIMEOUT(4)) u_dut_b (
    .clk_i(clk), .rst_i(rst_b), .instr_op_i(op), .funct_i(funct), .zero_i(zero),
    .mem_ready_i(rdy_b), .pc_write_o(pcw_b), .ir_write_o(irw_b), .mem_read_o(mr_b),
    .mem_write_o(mw_b), .iord_o(io_b), .reg_write_o(rw_b), .alu_src_a_o(asa_b),
    .reg_dst_o(rd_b), .mem_to_reg_o(m2r_b), .alu_src_b_o(asb_b), .pc_src_o(pcs_b),
    .alu_op_o(aop_b), .state_o(st_b), .illegal_o(ill_b), .timeout_o(to_b)
  );

  logic [17:0] ctl_a, ctl_b;
  assign ctl_a = {pcw_a, irw_a, mr_a, mw_a, io_a, rw_a, asa_a, rd_a, m2r_a, asb_a, pcs_a, aop_a};
  assign ctl_b = {pcw_b, irw_b, mr_b, mw_b, io_b, rw_b, asa_b, rd_b, m2r_b, asb_b, pcs_b, aop_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          sel;
    logic [3:0]  st;
    logic [17:0] ctl;
    logic [1:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miscmp = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] c(bit pcw, bit irw, bit mr, bit mw, bit io, bit rw, bit asa,
                                    logic [1:0] rd, logic [1:0] m2r, logic [1:0] asb,
                                    logic [1:0] pcs, logic [2:0] aop);
    return {pcw, irw, mr, mw, io, rw, asa, rd, m2r, asb, pcs, aop};
  endfunction

  function automatic logic [17:0] exp_ctl(state_e st, bit rdy, bit z);
    case (st)
      S_FETCH:    return c(rdy, rdy, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000);
      S_DECODE:   return c(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b00, 3'b000);
      S_MEM_ADDR: return c(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
      S_MEM_RD:   return c(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      S_MEM_WB:   return c(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000);
      S_MEM_WR:   return c(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      S_R_EXEC:   return c(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010);
      S_R_WB:     return c(0, 0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
      S_I_EXEC:   return c(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b10, 2'b00, 3'b000);
      S_I_WB:     return c(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
      S_BRANCH:   return c(z, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b001);
      S_JUMP:     return c(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000);
      S_JAL:      return c(1, 0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b00, 2'b10, 3'b000);
      S_JR:       return c(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
      default:    return '0;
    endcase
  endfunction

  function automatic bit rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus: drive ready, queue what the unit must show this cycle.
  task automatic step(input string tag, input bit sel, input state_e st, input bit rdy,
                      input logic [1:0] flg);
    exp_t e;
    bit   in_rst;
    if (sel) rdy_b = rdy; else rdy_a = rdy;
    in_rst = sel ? !rst_b : !rst_a;
    e.tag = tag;
    e.sel = sel;
    e.st  = st;
    e.ctl = in_rst ? 18'h0 : exp_ctl(st, rdy, zero);
    e.flg = flg;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input bit sel, input logic [5:0] o, input logic [5:0] f, input int waits);
    op = o;
    funct = f;
    for (int i = 0; i < waits; i++) step("fetch_wait", sel, S_FETCH, 1'b0, 2'b00);
    step("fetch", sel, S_FETCH, 1'b1, 2'b00);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check_val({mon_e.tag, "/state"}, 32'(mon_e.sel ? st_b : st_a), 32'(mon_e.st));
      check_val({mon_e.tag, "/ctl"}, 32'(mon_e.sel ? ctl_b : ctl_a), 32'(mon_e.ctl));
      check_val({mon_e.tag, "/flags"}, 32'(mon_e.sel ? {ill_b, to_b} : {ill_a, to_a}),
                32'(mon_e.flg));
    end
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rdy_a = 1'b1; rdy_b = 1'b0;
    op = 6'h00; funct = 6'h20; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("rst_hold", 0, S_FETCH, 1'b1, 2'b00);
    rst_a = 1'b1;

    fetch(0, 6'h00, 6'h20, 0);
    step("add_dec", 0, S_DECODE, rnd(), 2'b00);
    step("add_ex", 0, S_R_EXEC, rnd(), 2'b00);
    step("add_wb", 0, S_R_WB, rnd(), 2'b00);

    fetch(0, 6'h23, 6'h00, 0);
    step("lw_dec", 0, S_DECODE, rnd(), 2'b00);
    step("lw_addr", 0, S_MEM_ADDR, rnd(), 2'b00);
    for (int i = 0; i < 3; i++) step("lw_rd_wait", 0, S_MEM_RD, 1'b0, 2'b00);
    step("lw_rd", 0, S_MEM_RD, 1'b1, 2'b00);
    step("lw_wb", 0, S_MEM_WB, rnd(), 2'b00);

    fetch(0, 6'h2B, 6'h11, 1);
    step("sw_dec", 0, S_DECODE, rnd(), 2'b00);
    step("sw_addr", 0, S_MEM_ADDR, rnd(), 2'b00);
    step("sw_wr_wait", 0, S_MEM_WR, 1'b0, 2'b00);
    step("sw_wr", 0, S_MEM_WR, 1'b1, 2'b00);

    fetch(0, 6'h08, 6'h08, 0);
    step("addi_dec", 0, S_DECODE, rnd(), 2'b00);
    step("addi_ex", 0, S_I_EXEC, rnd(), 2'b00);
    step("addi_wb", 0, S_I_WB, rnd(), 2'b00);

    zero = 1'b1;
    fetch(0, 6'h04, 6'h00, 0);
    step("beq_dec", 0, S_DECODE, rnd(), 2'b00);
    step("beq_taken", 0, S_BRANCH, rnd(), 2'b00);
    zero = 1'b0;
    fetch(0, 6'h04, 6'h00, 0);
    step("beq_dec", 0, S_DECODE, rnd(), 2'b00);
    step("beq_not", 0, S_BRANCH, rnd(), 2'b00);
    zero = 1'b1;

    fetch(0, 6'h02, 6'h00, 0);
    step("j_dec", 0, S_DECODE, rnd(), 2'b00);
    step("j_ex", 0, S_JUMP, rnd(), 2'b00);
    fetch(0, 6'h03, 6'h00, 0);
    step("jal_dec", 0, S_DECODE, rnd(), 2'b00);
    step("jal_ex", 0, S_JAL, rnd(), 2'b00);
    fetch(0, 6'h00, 6'h08, 0);
    step("jr_dec", 0, S_DECODE, rnd(), 2'b00);
    step("jr_ex", 0, S_JR, rnd(), 2'b00);

    fetch(0, 6'h00, 6'h22, 15);
    step("edge_dec", 0, S_DECODE, rnd(), 2'b00);
    step("edge_ex", 0, S_R_EXEC, rnd(), 2'b00);
    step("edge_wb", 0, S_R_WB, rnd(), 2'b00);

    fetch(0, 6'h23, 6'h00, 0);
    step("abort_dec", 0, S_DECODE, rnd(), 2'b00);
    step("abort_addr", 0, S_MEM_ADDR, rnd(), 2'b00);
    step("abort_wait", 0, S_MEM_RD, 1'b0, 2'b00);
    step("abort_wait", 0, S_MEM_RD, 1'b0, 2'b00);
    rst_a = 1'b0;
    step("abort_rst", 0, S_FETCH, 1'b1, 2'b00);
    step("abort_rst", 0, S_FETCH, 1'b0, 2'b00);
    rst_a = 1'b1;

    fetch(0, 6'h3F, 6'h00, 0);
    step("ill_dec", 0, S_DECODE, rnd(), 2'b00);
    for (int i = 0; i < 20; i++) begin
      zero = rnd();
      step("ill_fault", 0, S_FAULT, rnd(), 2'b10);
    end
    rst_a = 1'b0;
    step("ill_rst", 0, S_FETCH, 1'b1, 2'b00);

    rst_b = 1'b1;
    for (int i = 0; i < 4; i++) step("to_fetch", 1, S_FETCH, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) step("to_fault", 1, S_FAULT, rnd(), 2'b01);
    rst_b = 1'b0;
    step("to_rst", 1, S_FETCH, 1'b1, 2'b00);
    rst_b = 1'b1;

    fetch(1, 6'h2B, 6'h00, 3);
    step("to_sw_dec", 1, S_DECODE, rnd(), 2'b00);
    step("to_sw_addr", 1, S_MEM_ADDR, rnd(), 2'b00);
    for (int i = 0; i < 4; i++) step("to_sw_wait", 1, S_MEM_WR, 1'b0, 2'b00);
    step("to_sw_fault", 1, S_FAULT, 1'b1, 2'b01);
    step("to_sw_fault", 1, S_FAULT, 1'b0, 2'b01);
    rst_b = 1'b0;
    step("to_sw_rst", 1, S_FETCH, 1'b0, 2'b00);

    @(negedge clk);
    #1;
    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, which is the maximum number of consecutive wait cycles on one memory access before a fault.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs instr_op_i (6 bits, IR[31:26]), funct_i (6 bits, IR[5:0]), zero_i (1 bit, ALU zero) and mem_ready_i (1 bit, memory access completes this cycle).
REQ-005 SHALL have 1-bit outputs pc_write_o, ir_write_o, mem_read_o, mem_write_o, iord_o (0 = address from PC, 1 = address from ALUOut), reg_write_o and alu_src_a_o (0 = PC, 1 = rs).
REQ-006 SHALL have 2-bit outputs reg_dst_o (00 rt, 01 rd, 10 $31), mem_to_reg_o (00 ALUOut, 01 MDR, 10 PC), alu_src_b_o (00 rt, 01 constant 4, 10 sign-extend, 11 sign-extend<<2) and pc_src_o (00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],00}, 11 rs).
REQ-007 SHALL have outputs alu_op_o (3 bits: 000 add, 001 sub, 010 funct-decoded), state_o (4 bits, current state) and 1-bit sticky flags illegal_o and timeout_o.

Function
REQ-008 SHALL implement a Moore FSM with states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR and FAULT. Unlisted outputs are 0 in every state.
REQ-009 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000 and pc_src=00. It SHALL drive pc_write = ir_write = mem_ready_i, stay in FETCH while mem_ready_i=0, and go to DECODE when mem_ready_i=1.
REQ-010 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=000 to precompute the branch target. Next state by opcode:
- 0x23 or 0x2B -> MEM_ADDR
- 0x00 with funct 0x08 -> JR; 0x00 otherwise -> R_EXEC
- 0x08 -> I_EXEC
- 0x04 -> BRANCH
- 0x02 -> JUMP
- 0x03 -> JAL
- any other opcode -> FAULT with illegal_o set
REQ-011 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000, then go to MEM_RD if the opcode is 0x23, else to MEM_WR.
REQ-012 MEM_RD SHALL drive mem_read=1 and iord=1, staying until mem_ready_i=1, then go to MEM_WB. MEM_WB SHALL drive reg_write=1, reg_dst=00 and mem_to_reg=01, then go to FETCH.
REQ-013 MEM_WR SHALL drive mem_write=1 and iord=1, staying until mem_ready_i=1, then go to FETCH.
REQ-014 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=010, then go to R_WB. R_WB SHALL drive reg_write=1, reg_dst=01 and mem_to_reg=00, then go to FETCH.
REQ-015 I_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000, then go to I_WB. I_WB SHALL drive reg_write=1, reg_dst=00 and mem_to_reg=00, then go to FETCH.
REQ-016 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01 and pc_write=zero_i, then go to FETCH.
REQ-017 JUMP SHALL drive pc_write=1 and pc_src=10, then go to FETCH.
REQ-018 JAL SHALL drive pc_write=1, pc_src=10, reg_write=1, reg_dst=10 and mem_to_reg=10, so that the old PC+4 is written to $31 in the same cycle. It then goes to FETCH.
REQ-019 JR SHALL drive pc_write=1 and pc_src=11, then go to FETCH.
REQ-020 Latencies SHALL be: lw 5 cycles and sw 4 cycles, each plus wait cycles; R-type and addi 4; beq, j, jal and jr 3.
REQ-021 The wait counter SHALL clear on entry to FETCH, MEM_RD and MEM_WR and on every cycle with mem_ready_i=1, and increment in those states while mem_ready_i=0. When it reaches MEM_TIMEOUT-1 with mem_ready_i still 0, the next state SHALL be FAULT with timeout_o set.
REQ-022 FAULT SHALL hold every control output at 0 and SHALL be left only by reset. illegal_o and timeout_o SHALL stay set until reset.
REQ-023 mem_ready_i SHALL be ignored in all states other than FETCH, MEM_RD and MEM_WR.

Reset
REQ-024 While rst_i=0, state SHALL be FETCH, the wait counter 0, illegal_o and timeout_o 0, and every control output forced to 0, all asynchronously.
REQ-025 On the first rising edge after rst_i goes high, the FSM SHALL evaluate FETCH normally. Reset in any state, including mid-wait or FAULT, SHALL abort the instruction with no partial write strobe after reset is asserted.

Structure
REQ-026 Package multi_cycle_pkg SHALL hold the state encoding, the opcode and funct constants, the alu_op, pc_src, reg_dst, mem_to_reg and alu_src_b encodings, and the default for MEM_TIMEOUT.
REQ-027 The wait/timeout counter SHALL be a sub-module mc_wait_timer with inputs clear, count and limit, and output expired. Next-state logic and output decode SHALL stay in multi_cycle_ctrl.

Verification
REQ-028 Reset release, then op 0x00 / funct 0x20 with mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=01 only in cycle 4.
REQ-029 op 0x23 with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles; MEM_WB asserts reg_write with mem_to_reg=01; total 8 cycles.
REQ-030 op 0x04 with zero_i=1, then again with zero_i=0 -> BRANCH pc_write=1 with pc_src=01 in the first case, pc_write=0 in the second.
REQ-031 op 0x03, then op 0x00 / funct 0x08 -> JAL: reg_dst=10, mem_to_reg=10, pc_src=10. JR: pc_src=11. Each takes 3 cycles.
REQ-032 op 0x3F -> FAULT, illegal_o=1, all strobes 0 for 20 cycles. With MEM_TIMEOUT=4 and mem_ready=0 in FETCH -> FAULT after 4 cycles, timeout_o=1. rst_i=0 -> both flags clear and state_o=FETCH.
